// File: rtl/adc_set_router.sv
// adc_set_router: runtime-configurable, sample-aligned channel router.
// Routes whole channel slices (SAMPLES_PER_CLK samples each) using set swap/reverse
// modes or a custom per-output permutation table. The new routing is applied on a
// qualifying input beat, either the next valid beat or the next valid sync marker.
// Two register stages: stage 1 captures the beat together with its per-output
// selects; stage 2 registers the muxed result.
module adc_set_router #(
  parameter int          CHANNEL_COUNT   = 16,
  parameter int          SET_SIZE        = 2,
  parameter int          SAMPLE_WIDTH    = 16,
  parameter int          SAMPLES_PER_CLK = 2,
  parameter logic [2:0]  DEFAULT_MODE    = 3'b011,
  parameter int          SEL_WIDTH       = $clog2(CHANNEL_COUNT) + 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 cfgWrite,
  input  logic [2:0]                                           cfgMode,
  input  logic                                                 cfgImmediate,
  input  logic                                                 tableWrite,
  input  logic [$clog2(CHANNEL_COUNT)-1:0]                     tableAddr,
  input  logic [SEL_WIDTH-1:0]                                 tableData,
  input  logic                                                 inValid,
  input  logic                                                 inSync,
  input  logic [CHANNEL_COUNT*SAMPLES_PER_CLK*SAMPLE_WIDTH-1:0] inData,
  output logic                                                 outValid,
  output logic                                                 outSync,
  output logic [CHANNEL_COUNT*SAMPLES_PER_CLK*SAMPLE_WIDTH-1:0] outData,
  output logic [2:0]                                           activeMode,
  output logic                                                 updatePending,
  output logic [15:0]                                          switchCount
);

  localparam int NSETS = CHANNEL_COUNT / SET_SIZE;
  localparam int CW    = SAMPLES_PER_CLK * SAMPLE_WIDTH;
  localparam int DW    = CHANNEL_COUNT * CW;

  // Source channel for output channel c under a given mode / table entry.
  function automatic logic [SEL_WIDTH-1:0] map_sel(input logic [2:0] mode,
                                                   input logic [SEL_WIDTH-1:0] entry,
                                                   input int c);
    int s;
    int k;
    int f;
    s = c / SET_SIZE;
    k = c % SET_SIZE;
    f = s;
    if (mode[0]) begin
      f = s ^ 1;
      // with an odd set count the last set has no partner and stays put
      if (f >= NSETS) f = s;
    end
    if (mode[1]) f = NSETS - 1 - f;
    if (mode[2]) return entry;
    return SEL_WIDTH'(f * SET_SIZE + k);
  endfunction

  logic [2:0]           active_mode_reg;
  logic [2:0]           pending_mode_reg;
  logic                 pending_imm_reg;
  logic                 update_pending_reg;
  logic [15:0]          switch_count_reg;
  logic [SEL_WIDTH-1:0] pending_table [CHANNEL_COUNT];
  logic [SEL_WIDTH-1:0] active_table  [CHANNEL_COUNT];
  logic [SEL_WIDTH-1:0] sel_next      [CHANNEL_COUNT];
  logic [SEL_WIDTH-1:0] sel_reg       [CHANNEL_COUNT];
  logic [DW-1:0]        data_s1_reg;
  logic [DW-1:0]        routed_next;
  logic [DW-1:0]        out_data_reg;
  logic                 valid_s1_reg;
  logic                 sync_s1_reg;
  logic                 out_valid_reg;
  logic                 out_sync_reg;
  logic                 cfg_busy;
  logic                 apply;

  // A write in the same cycle defers the apply so the write is never split
  // between the old and new configuration.
  assign cfg_busy = cfgWrite | tableWrite;
  assign apply    = update_pending_reg & inValid & (pending_imm_reg | inSync) & ~cfg_busy;

  // Pending/active configuration, apply event and saturating switch counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_mode_reg    <= DEFAULT_MODE;
      pending_mode_reg   <= DEFAULT_MODE;
      pending_imm_reg    <= 1'b0;
      update_pending_reg <= 1'b0;
      switch_count_reg   <= 16'h0000;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        pending_table[c] <= SEL_WIDTH'(c);
        active_table[c]  <= SEL_WIDTH'(c);
      end
    end else begin
      if (cfgWrite) begin
        pending_mode_reg <= cfgMode;
        pending_imm_reg  <= cfgImmediate;
      end
      if (tableWrite) pending_table[tableAddr] <= tableData;
      if (cfg_busy) begin
        update_pending_reg <= 1'b1;
      end else if (apply) begin
        update_pending_reg <= 1'b0;
        active_mode_reg    <= pending_mode_reg;
        for (int c = 0; c < CHANNEL_COUNT; c++) active_table[c] <= pending_table[c];
        if (switch_count_reg != 16'hFFFF) switch_count_reg <= switch_count_reg + 16'h0001;
      end
    end
  end

  // Per-output selects; the applying beat already uses the pending config.
  always_comb begin
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      sel_next[c] = apply ? map_sel(pending_mode_reg, pending_table[c], c)
                          : map_sel(active_mode_reg, active_table[c], c);
    end
  end

  // Stage 1: capture the beat and its selects together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_s1_reg  <= '0;
      valid_s1_reg <= 1'b0;
      sync_s1_reg  <= 1'b0;
      for (int c = 0; c < CHANNEL_COUNT; c++) sel_reg[c] <= map_sel(DEFAULT_MODE, SEL_WIDTH'(c), c);
    end else begin
      data_s1_reg  <= inData;
      valid_s1_reg <= inValid;
      sync_s1_reg  <= inSync;
      for (int c = 0; c < CHANNEL_COUNT; c++) sel_reg[c] <= sel_next[c];
    end
  end

  // Slice mux driven only by registered selects; out-of-range selects give zeros.
  always_comb begin
    routed_next = '0;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      if (int'(sel_reg[c]) < CHANNEL_COUNT) begin
        routed_next[c*CW +: CW] = data_s1_reg[int'(sel_reg[c])*CW +: CW];
      end
    end
  end

  // Stage 2: register the routed beat and its qualifiers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sync_reg  <= 1'b0;
    end else begin
      out_data_reg  <= routed_next;
      out_valid_reg <= valid_s1_reg;
      out_sync_reg  <= sync_s1_reg;
    end
  end

  assign outData       = out_data_reg;
  assign outValid      = out_valid_reg;
  assign outSync       = out_sync_reg;
  assign activeMode    = active_mode_reg;
  assign updatePending = update_pending_reg;
  assign switchCount   = switch_count_reg;

endmodule
